// File: rtl/c1_responder_pkg.sv
// C1 bus encodings, field widths and responder FSM states shared by the responder RTL and its bench.
// WRITE32 and RESPONSE share code 7; direction of drive (CPU vs responder) disambiguates them.
package c1_bus_pkg;

  localparam int TAG_BITS    = 10;
  localparam int SET_BITS    = 5;
  localparam int OFFSET_BITS = 4;
  localparam int A1_BITS     = TAG_BITS + SET_BITS;
  localparam int ADDR_BITS   = A1_BITS + OFFSET_BITS;
  localparam int D1_BITS     = 16;
  localparam int WORD_BITS   = 32;

  typedef logic [2:0] c1_cmd_t;

  localparam c1_cmd_t C1_NOP             = 3'd0;
  localparam c1_cmd_t C1_READ8           = 3'd1;
  localparam c1_cmd_t C1_READ16          = 3'd2;
  localparam c1_cmd_t C1_READ32          = 3'd3;
  localparam c1_cmd_t C1_INVALIDATE_LINE = 3'd4;
  localparam c1_cmd_t C1_WRITE8          = 3'd5;
  localparam c1_cmd_t C1_WRITE16         = 3'd6;
  localparam c1_cmd_t C1_WRITE32         = 3'd7;
  localparam c1_cmd_t C1_RESPONSE        = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR2,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_RESP_LO,
    ST_RESP_HI
  } c1_state_t;

  function automatic logic is_write(input c1_cmd_t c);
    return (c == C1_WRITE8) || (c == C1_WRITE16) || (c == C1_WRITE32);
  endfunction

endpackage

// File: rtl/c1_responder_if.sv
// Request/response port between the C1 responder and the cache core.
// The responder is the master: it raises req_valid and waits for req_ready, then for a one-cycle rsp_valid.
interface c1_responder_if #(
  parameter int ADDR_BITS = c1_bus_pkg::ADDR_BITS
) ();

  logic                      req_valid;
  logic                      req_ready;
  c1_bus_pkg::c1_cmd_t       req_cmd;
  logic [ADDR_BITS-1:0]      req_addr;
  logic [31:0]               req_wdata;
  logic                      rsp_valid;
  logic [31:0]               rsp_rdata;

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/c1_responder_bus_driver.sv
// Registered tri-state drivers for the shared C1/D1 lines; one cycle from *_nxt to the pins.
// Enables clear on reset so the bus is released at the reset edge.
module c1_bus_driver
  import c1_bus_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                c1_oe_nxt,
  input  c1_cmd_t             c1_val_nxt,
  input  logic                d1_oe_nxt,
  input  logic [D1_BITS-1:0]  d1_val_nxt,
  inout  wire  [2:0]          C1,
  inout  wire  [D1_BITS-1:0]  D1
);

  logic                c1_oe;
  c1_cmd_t             c1_val;
  logic                d1_oe;
  logic [D1_BITS-1:0]  d1_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      c1_oe  <= 1'b0;
      c1_val <= C1_NOP;
      d1_oe  <= 1'b0;
      d1_val <= '0;
    end else begin
      c1_oe  <= c1_oe_nxt;
      c1_val <= c1_val_nxt;
      d1_oe  <= d1_oe_nxt;
      d1_val <= d1_val_nxt;
    end
  end

  assign C1 = c1_oe ? c1_val : 3'bz;
  assign D1 = d1_oe ? d1_val : {D1_BITS{1'bz}};

endmodule

// File: rtl/c1_responder.sv
// Cache-side C1 bus endpoint: decodes the two-cycle command/address phase, issues one core request, drives RESPONSE.
// Zero-wait core gives RESPONSE in t3; req_valid holds with stable fields until req_ready.
module c1_responder
  import c1_bus_pkg::*;
#(
  parameter int TAG_BITS    = c1_bus_pkg::TAG_BITS,
  parameter int SET_BITS    = c1_bus_pkg::SET_BITS,
  parameter int OFFSET_BITS = c1_bus_pkg::OFFSET_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  inout  wire  [2:0]                    C1,
  inout  wire  [D1_BITS-1:0]            D1,
  input  logic [TAG_BITS+SET_BITS-1:0]  A1,
  c1_responder_if.master                core,
  output logic                          busy
);

  c1_state_t                       state_q, state_d;
  c1_cmd_t                         cmd_q;
  c1_cmd_t                         c1_cmd;
  logic [TAG_BITS+SET_BITS-1:0]    a1_q;
  logic [OFFSET_BITS-1:0]          off_q;
  logic [31:0]                     wdata_q;
  logic [15:0]                     rdata_hi_q;
  logic                            rsp_take;

  logic                            c1_oe_nxt;
  c1_cmd_t                         c1_val_nxt;
  logic                            d1_oe_nxt;
  logic [D1_BITS-1:0]              d1_val_nxt;

  // Undriven or unknown C1 falls through to the default and reads as NOP.
  always_comb begin
    c1_cmd = C1_NOP;
    case (C1)
      C1_READ8, C1_READ16, C1_READ32, C1_INVALIDATE_LINE,
      C1_WRITE8, C1_WRITE16, C1_WRITE32: c1_cmd = C1;
      default: c1_cmd = C1_NOP;
    endcase
  end

  assign rsp_take = core.rsp_valid &&
                    (((state_q == ST_ISSUE) && core.req_ready) || (state_q == ST_WAIT_RSP));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (c1_cmd != C1_NOP) state_d = ST_ADDR2;
      ST_ADDR2:    state_d = ST_ISSUE;
      ST_ISSUE:    if (core.req_ready) state_d = core.rsp_valid ? ST_RESP_LO : ST_WAIT_RSP;
      ST_WAIT_RSP: if (core.rsp_valid) state_d = ST_RESP_LO;
      ST_RESP_LO:  state_d = (cmd_q == C1_READ32) ? ST_RESP_HI : ST_IDLE;
      ST_RESP_HI:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= C1_NOP;
      a1_q       <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      rdata_hi_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && (c1_cmd != C1_NOP)) begin
        cmd_q <= c1_cmd;
        a1_q  <= A1;
        case (c1_cmd)
          C1_WRITE8:             wdata_q <= {24'h0, D1[7:0]};
          C1_WRITE16, C1_WRITE32: wdata_q <= {16'h0, D1};
          default:               wdata_q <= '0;
        endcase
      end
      if (state_q == ST_ADDR2) begin
        off_q <= A1[OFFSET_BITS-1:0];
        if (cmd_q == C1_WRITE32) wdata_q[31:16] <= D1;
      end
      if (rsp_take) rdata_hi_q <= core.rsp_rdata[31:16];
    end
  end

  // Pin values are registered, so they are chosen from the state being entered.
  // NOP is held only once ISSUE has lasted past the t2 turnaround cycle.
  always_comb begin
    c1_oe_nxt  = 1'b0;
    c1_val_nxt = C1_NOP;
    d1_oe_nxt  = 1'b0;
    d1_val_nxt = '0;
    case (state_d)
      ST_ISSUE, ST_WAIT_RSP: begin
        c1_oe_nxt = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RSP);
      end
      ST_RESP_LO: begin
        c1_oe_nxt  = 1'b1;
        c1_val_nxt = C1_RESPONSE;
        case (cmd_q)
          C1_READ8: begin
            d1_oe_nxt  = 1'b1;
            d1_val_nxt = {8'h0, core.rsp_rdata[7:0]};
          end
          C1_READ16, C1_READ32: begin
            d1_oe_nxt  = 1'b1;
            d1_val_nxt = core.rsp_rdata[15:0];
          end
          default: d1_oe_nxt = 1'b0;
        endcase
      end
      ST_RESP_HI: begin
        c1_oe_nxt  = 1'b1;
        c1_val_nxt = C1_RESPONSE;
        d1_oe_nxt  = 1'b1;
        d1_val_nxt = rdata_hi_q;
      end
      default: c1_oe_nxt = 1'b0;
    endcase
  end

  c1_bus_driver u_drv (
    .clk        (clk),
    .reset      (reset),
    .c1_oe_nxt  (c1_oe_nxt),
    .c1_val_nxt (c1_val_nxt),
    .d1_oe_nxt  (d1_oe_nxt),
    .d1_val_nxt (d1_val_nxt),
    .C1         (C1),
    .D1         (D1)
  );

  assign core.req_valid = (state_q == ST_ISSUE);
  assign core.req_cmd   = cmd_q;
  assign core.req_addr  = {a1_q, off_q};
  assign core.req_wdata = wdata_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
